// File: rtl/mem_io_pkg.sv
// Shared constants, FSM encoding and bus payload type for the memory/IO responder.
package mem_io_pkg;

    localparam int unsigned BYTE_WID = 8;
    localparam int unsigned CNT_WID  = 32;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_UART_OFS = 3'd0;
    localparam logic [2:0] IO_CLK_OFS  = 3'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic                is_io;
        logic                wr;
        logic [2:0]          ofs;
        logic [BYTE_WID-1:0] data;
    } bus_req_t;

    // Byte lane 'sel' of a counter word.
    function automatic logic [BYTE_WID-1:0] cnt_byte(input logic [CNT_WID-1:0] v,
                                                     input logic [1:0]         sel);
        return v[32'(sel) * BYTE_WID +: BYTE_WID];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for UART output; pointers wrap by power-of-two masking.
module uart_tx_fifo
    import mem_io_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WID   = BYTE_WID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WID-1:0]         push_data,
    input  logic                   pop,
    output logic [WID-1:0]         pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_WID  = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_WID + 1;
    localparam int unsigned PTR_MASK = DEPTH - 1;

    logic [WID-1:0]     store [DEPTH];
    logic [PTR_WID-1:0] wr_ptr;
    logic [PTR_WID-1:0] rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= PTR_WID'((32'(wr_ptr) + 32'd1) & PTR_MASK);
            end
            if (pop_ok) begin
                rd_ptr <= PTR_WID'((32'(rd_ptr) + 32'd1) & PTR_MASK);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Far-side responder for the CPU byte bus: main RAM plus the IO window
// (UART in/out, cycle counter, program-stop handshake).
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WID  = 17,
    parameter string       INIT_FILE     = "",
    parameter int unsigned TX_FIFO_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [31:0]         mem_a,
    input  logic                mem_wr,
    input  logic [BYTE_WID-1:0] mem_dout,
    output logic [BYTE_WID-1:0] mem_din,
    output logic                io_buffer_full,
    input  logic                uart_rx_valid,
    input  logic [BYTE_WID-1:0] uart_rx_data,
    output logic                uart_rx_ready,
    output logic                uart_tx_valid,
    output logic [BYTE_WID-1:0] uart_tx_data,
    input  logic                uart_tx_ready,
    output logic                program_done,
    output logic                tx_overflow
);

    localparam int unsigned RAM_BYTES    = 1 << RAM_ADDR_WID;
    localparam int unsigned FIFO_CNT_WID = $clog2(TX_FIFO_DEPTH) + 1;

    logic [BYTE_WID-1:0]     ram [RAM_BYTES];
    logic [RAM_ADDR_WID-1:0] ram_idx;
    bus_req_t                req;
    logic                    unused_addr;

    logic [CNT_WID-1:0]      cnt;
    logic [CNT_WID-1:0]      cnt_snap;
    logic [BYTE_WID-1:0]     io_rdata;

    state_e                  state;
    state_e                  state_next;
    logic                    io_wr_en;

    logic                    uart_wr;
    logic                    stop_wr;
    logic                    clk_rd;
    logic                    push_req;
    logic [BYTE_WID-1:0]     push_byte;
    logic                    tx_pop;
    logic [BYTE_WID-1:0]     fifo_head;
    logic [FIFO_CNT_WID-1:0] fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign req = '{is_io: (mem_a[17:16] == IO_SEL), wr: mem_wr, ofs: mem_a[2:0], data: mem_dout};
    assign ram_idx     = mem_a[RAM_ADDR_WID-1:0];
    assign unused_addr = ^mem_a;

    assign uart_wr = req.is_io & req.wr & (req.ofs == IO_UART_OFS) & (req.data != '0);
    assign stop_wr = req.is_io & req.wr & (req.ofs == IO_CLK_OFS);
    assign clk_rd  = req.is_io & ~req.wr & (req.ofs == IO_CLK_OFS);

    assign push_req  = io_wr_en & (uart_wr | stop_wr);
    assign push_byte = stop_wr ? '0 : req.data;

    // Consume the input byte in the same cycle the CPU reads it.
    assign uart_rx_ready = ~rst_in & req.is_io & ~req.wr & (req.ofs == IO_UART_OFS) & uart_rx_valid;

    assign uart_tx_valid  = ~fifo_empty;
    assign uart_tx_data   = fifo_empty ? '0 : fifo_head;
    assign tx_pop         = uart_tx_valid & uart_tx_ready;
    assign io_buffer_full = (fifo_count >= FIFO_CNT_WID'(TX_FIFO_DEPTH - 1));

    always_ff @(posedge clk_in) begin
        if (~req.is_io & req.wr) begin
            ram[ram_idx] <= req.data;
        end
    end

    // Offsets 5-7 come from the snapshot so a multi-byte read is coherent.
    always_comb begin
        io_rdata = '0;
        if (req.ofs[2]) begin
            io_rdata = (req.ofs[1:0] == 2'd0) ? cnt[BYTE_WID-1:0]
                                              : cnt_byte(cnt_snap, req.ofs[1:0]);
        end else if (req.ofs == IO_UART_OFS) begin
            io_rdata = uart_rx_valid ? uart_rx_data : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din      <= '0;
            cnt          <= '0;
            cnt_snap     <= '0;
            tx_overflow  <= 1'b0;
            program_done <= 1'b0;
        end else begin
            cnt <= cnt + CNT_WID'(1);
            if (~req.wr) begin
                mem_din <= req.is_io ? io_rdata : ram[ram_idx];
            end
            if (clk_rd) begin
                cnt_snap <= cnt;
            end
            if (push_req & fifo_full) begin
                tx_overflow <= 1'b1;
            end
            program_done <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (stop_wr) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        io_wr_en = 1'b0;
        if (state == RUN) begin
            io_wr_en = 1'b1;
        end
    end

    uart_tx_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WID   (BYTE_WID)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push_req),
        .push_data (push_byte),
        .pop       (tx_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        program_done;
    logic        tx_overflow;

    int          n_cmp;
    int          n_err;
    logic [31:0] exp_cnt;
    logic [31:0] cnt_seen;
    logic [7:0]  exp_drain [4];
    int          pops;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_ready  (uart_rx_ready),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_ready  (uart_tx_ready),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    // One edge; the counter model tracks the value the DUT samples at that edge.
    task automatic tick();
        @(posedge clk_in);
        cnt_seen = exp_cnt;
        if (rst_in) exp_cnt = 32'd0;
        else        exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = 32'd0;
        cnt_seen = 32'd0;
        exp_drain = '{8'h11, 8'h22, 8'h33, 8'h00};
        rst_in = 1'b1;
        mem_a = 32'd0;
        mem_wr = 1'b0;
        mem_dout = 8'd0;
        uart_rx_valid = 1'b0;
        uart_rx_data = 8'd0;
        uart_tx_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mem_din",  32'(mem_din), 32'h0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst_tx_data",  32'(uart_tx_data), 32'h0);
        check("rst_buf_full", 32'(io_buffer_full), 32'h0);
        check("rst_done",     32'(program_done), 32'h0);
        check("rst_ovf",      32'(tx_overflow), 32'h0);
        check("rst_rx_ready", 32'(uart_rx_ready), 32'h0);
        rst_in = 1'b0;

        // Counter coherence across the 0xFF -> 0x100 carry
        for (int g = 0; g < 1000 && exp_cnt != 32'd255; g++) bus(32'h0, 1'b0, 8'h0);
        bus(32'h30004, 1'b0, 8'h0);
        check("cnt_b0", 32'(mem_din), 32'hFF);
        bus(32'h30005, 1'b0, 8'h0);
        check("cnt_b1", 32'(mem_din), 32'h00);
        bus(32'h30006, 1'b0, 8'h0);
        check("cnt_b2", 32'(mem_din), 32'h00);
        bus(32'h30007, 1'b0, 8'h0);
        check("cnt_b3", 32'(mem_din), 32'h00);

        // RAM round trip and hold-on-write
        bus(32'h00010, 1'b1, 8'hA5);
        bus(32'h00010, 1'b0, 8'h0);
        check("ram_rd_a5", 32'(mem_din), 32'hA5);
        bus(32'h00011, 1'b1, 8'h3C);
        check("ram_wr_hold", 32'(mem_din), 32'hA5);
        bus(32'h00011, 1'b0, 8'h0);
        check("ram_rd_3c", 32'(mem_din), 32'h3C);
        bus(32'h10010, 1'b1, 8'h77);
        bus(32'h00010, 1'b0, 8'h0);
        check("ram_no_alias", 32'(mem_din), 32'hA5);
        bus(32'h10010, 1'b0, 8'h0);
        check("ram_rd_77", 32'(mem_din), 32'h77);

        // UART input
        mem_a = 32'h30000; mem_wr = 1'b0; uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        #1;
        check("rx_ready_pulse", 32'(uart_rx_ready), 32'h1);
        tick();
        check("rx_data", 32'(mem_din), 32'h5A);
        uart_rx_valid = 1'b0;
        #1;
        check("rx_ready_idle", 32'(uart_rx_ready), 32'h0);
        tick();
        check("rx_empty_zero", 32'(mem_din), 32'h00);
        uart_rx_valid = 1'b1;
        mem_a = 32'h30002;
        #1;
        check("rx_ready_ofs2", 32'(uart_rx_ready), 32'h0);
        tick();
        check("io_ofs2_zero", 32'(mem_din), 32'h00);
        uart_rx_valid = 1'b0;

        // UART output with a zero byte in the stream
        uart_tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'h41);
        check("tx_v_41", 32'(uart_tx_valid), 32'h1);
        check("tx_d_41", 32'(uart_tx_data), 32'h41);
        bus(32'h30000, 1'b1, 8'h00);
        check("tx_zero_skip", 32'(uart_tx_valid), 32'h0);
        bus(32'h30000, 1'b1, 8'h42);
        check("tx_v_42", 32'(uart_tx_valid), 32'h1);
        check("tx_d_42", 32'(uart_tx_data), 32'h42);
        bus(32'h0, 1'b0, 8'h0);
        check("tx_drained", 32'(uart_tx_valid), 32'h0);

        // FIFO fill, almost-full flag and overflow
        uart_tx_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            bus(32'h30000, 1'b1, 8'(i));
            if (i == 6) check("buf_full_at6", 32'(io_buffer_full), 32'h0);
        end
        check("buf_full_at7", 32'(io_buffer_full), 32'h1);
        bus(32'h30000, 1'b1, 8'h08);
        check("ovf_at8", 32'(tx_overflow), 32'h0);
        bus(32'h30000, 1'b1, 8'h09);
        check("ovf_at9", 32'(tx_overflow), 32'h1);
        mem_a = 32'h0; mem_wr = 1'b0; uart_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("fill_v", 32'(uart_tx_valid), 32'h1);
            check("fill_d", 32'(uart_tx_data), 32'(i));
            tick();
        end
        check("fill_empty", 32'(uart_tx_valid), 32'h0);
        check("fill_buf_clr", 32'(io_buffer_full), 32'h0);

        // Stop handshake with a toggling sink
        uart_tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h11);
        bus(32'h30000, 1'b1, 8'h22);
        bus(32'h30000, 1'b1, 8'h33);
        bus(32'h30004, 1'b1, 8'h99);
        check("stop_done_lo", 32'(program_done), 32'h0);
        bus(32'h30000, 1'b1, 8'h77);
        mem_a = 32'h0; mem_wr = 1'b0;
        pops = 0;
        for (int c = 0; c < 40 && pops < 4; c++) begin
            uart_tx_ready = (c % 2 == 1);
            #1;
            if (uart_tx_valid && uart_tx_ready) begin
                check("drain_byte", 32'(uart_tx_data), 32'(exp_drain[pops]));
                pops++;
            end
            tick();
        end
        check("drain_count", 32'(pops), 32'd4);
        check("drain_empty", 32'(uart_tx_valid), 32'h0);
        check("done_not_yet", 32'(program_done), 32'h0);
        tick();
        check("done_set", 32'(program_done), 32'h1);
        uart_tx_ready = 1'b0;
        bus(32'h30000, 1'b1, 8'h55);
        check("done_wr_ignored", 32'(uart_tx_valid), 32'h0);
        bus(32'h30004, 1'b1, 8'h00);
        check("done_stop_ignored", 32'(uart_tx_valid), 32'h0);
        check("done_sticky", 32'(program_done), 32'h1);
        check("ovf_sticky", 32'(tx_overflow), 32'h1);

        // Reset in the middle of a drain
        mem_a = 32'h0; mem_wr = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("rst2_done", 32'(program_done), 32'h0);
        check("rst2_ovf", 32'(tx_overflow), 32'h0);
        bus(32'h30000, 1'b1, 8'h61);
        bus(32'h30000, 1'b1, 8'h62);
        bus(32'h30000, 1'b1, 8'h63);
        bus(32'h30004, 1'b1, 8'h00);
        check("mid_v", 32'(uart_tx_valid), 32'h1);
        check("mid_d", 32'(uart_tx_data), 32'h61);
        mem_a = 32'h0; mem_wr = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("mid_rst_valid", 32'(uart_tx_valid), 32'h0);
        check("mid_rst_done", 32'(program_done), 32'h0);
        bus(32'h30000, 1'b1, 8'h71);
        check("run_again_v", 32'(uart_tx_valid), 32'h1);
        check("run_again_d", 32'(uart_tx_data), 32'h71);
        bus(32'h00010, 1'b0, 8'h0);
        check("ram_kept_a5", 32'(mem_din), 32'hA5);
        bus(32'h10010, 1'b0, 8'h0);
        check("ram_kept_77", 32'(mem_din), 32'h77);
        bus(32'h30004, 1'b0, 8'h0);
        check("cnt_after_rst", 32'(mem_din), 32'(cnt_seen[7:0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
